sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter: the decoding end of the LFSR/comparator stochastic number generator path.
- Counts the 1s in a unipolar bitstream over one full LFSR period of 2^WIDTH-1 valid bits.
- Presents the count as a WIDTH-bit binary result through a valid/ready handshake.
- Sits downstream of the SC arithmetic network, on its output bit (e.g. output_circuit), and feeds a binary register or host interface.

Parameters:
- WIDTH, 8, width of the result and of the matching LFSR. Window length L = 2^WIDTH-1 valid bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that opens a new counting window.
- clear  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  in_bit is a valid stream sample this cycle.
- in_bit  input  1  stochastic stream bit.
- busy  output  1  high while in COUNT state.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_value  output  WIDTH  decoded value (ones count, or bipolar value when BIPOLAR_EN is defined).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ones=0, samples=0, busy=0, out_valid=0, out_value=0.
- FSM states: IDLE, COUNT, DONE.
- IDLE -> COUNT on start. Counters clear. The sample seen in the start cycle is not counted.
- COUNT:
  - Each cycle with in_valid=1: samples+1; ones+1 if in_bit=1.
  - in_valid=0 stalls both counters. There is no timeout.
  - When the increment takes samples to L (the 255th valid bit when WIDTH=8), out_value is registered from the final ones count, including that last bit, and the state moves to DONE.
  - out_valid rises the cycle after the last valid sample (latency 1).
- DONE:
  - out_valid=1 and out_value is held stable until out_ready=1.
  - On handshake (out_valid & out_ready): out_valid=0 next cycle, state goes to IDLE.
  - out_ready is don't-care while out_valid=0.
- start is ignored in COUNT and in DONE. A start in the same cycle as the DONE handshake is also ignored; start must be reissued from IDLE.
- clear has priority over every other event:
  - Next state is IDLE, counters return to 0, out_valid=0.
  - out_value keeps its last value.
- Arithmetic: ones and samples are WIDTH bits each. ones <= samples <= L, so no overflow is possible.
- Boundary cases:
  - All-0 stream -> 0.
  - All-1 stream -> L (0xFF at WIDTH=8).
- busy equals (state==COUNT).

Optional Feature:
- Macro: SC_DECODER_BIPOLAR_EN.
- When defined:
  - out_value is a two's-complement bipolar estimate, 2*ones - L, computed in WIDTH+1 bits.
  - The result is saturated to the signed WIDTH-bit range [-(2^(WIDTH-1)), 2^(WIDTH-1)-1] and presented as WIDTH bits.
  - At WIDTH=8, all-1 gives +127 (saturated from 255); all-0 gives -128 (saturated from -255); 128 ones gives +1.
- When undefined: unipolar; out_value = ones.
- Handshake and timing are identical in both modes.

Decomposition:
- Package sc_pkg holds:
  - the state enum type (IDLE/COUNT/DONE);
  - the WIDTH default constant;
  - a window-length function returning 2^w-1.
- One sub-module, sc_ones_counter: a WIDTH-bit enabled counter with synchronous clear and a terminal-count flag.
- Two instances: one for samples (enable in_valid), one for ones (enable in_valid & in_bit).

Test Plan:
- Reset mid-COUNT after 100 valid samples: rst_n low -> all outputs 0 immediately. A new start then yields a clean 255-sample window.
- start, then 255 valid bits from the repeating pattern 1,0 (128 ones) -> out_valid one cycle after the last sample, out_value=0x80 (bipolar build: 0x01).
- All-1 stream and all-0 stream -> 0xFF and 0x00 (bipolar build: 0x7F and 0x80).
- in_valid low on random cycles, including a 20-cycle gap -> result unchanged versus the gapless run; busy held high throughout.
- out_ready held low 10 cycles in DONE, with start pulsed meanwhile -> out_value stable, no new window. Handshake -> IDLE; the next start is accepted.
- clear at sample 50 of COUNT, and separately clear in DONE -> state IDLE, out_valid=0 next cycle, busy=0, no result emitted.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream decoder.
package sc_pkg;

  localparam int SC_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } sc_state_t;

  // Length of one maximal LFSR period for a w-bit register.
  function automatic int sc_window_len(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Enabled WIDTH-bit counter, sync clear; tc flags the increment that reaches 2^WIDTH-1.
// Zero latency on tc (combinational from count/en); no backpressure.
module sc_ones_counter
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam int LAST_M1_I = sc_window_len(WIDTH) - 1;
  localparam logic [WIDTH-1:0] LAST_M1 = LAST_M1_I[WIDTH-1:0];

  assign tc = en && (count == LAST_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Counts ones over a 2^WIDTH-1 sample window; result valid 1 cycle after the last sample, held until out_ready.
// Optional SC_DECODER_BIPOLAR_EN: result is saturated 2*ones-L instead of the raw ones count.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value
);

  sc_state_t        state, state_nxt;
  logic             cnt_clr, samp_en, ones_en;
  logic             samp_tc, ones_tc;
  logic             load_res;
  logic [WIDTH-1:0] samp_cnt, ones_cnt, ones_final, result;
  logic             unused_cnt;

  // Counters sit at zero outside COUNT, so entering COUNT always starts a clean window.
  assign cnt_clr = clear || (state != ST_COUNT);
  assign samp_en = (state == ST_COUNT) && in_valid;
  assign ones_en = samp_en && in_bit;

  sc_ones_counter #(.WIDTH(WIDTH)) u_samples (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (samp_en),
    .count (samp_cnt),
    .tc    (samp_tc)
  );

  sc_ones_counter #(.WIDTH(WIDTH)) u_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (ones_en),
    .count (ones_cnt),
    .tc    (ones_tc)
  );

  assign unused_cnt = &{1'b0, samp_cnt, ones_tc};

  // The closing sample is still in flight, so fold it in here.
  assign ones_final = ones_cnt + {{(WIDTH-1){1'b0}}, in_bit};

`ifdef SC_DECODER_BIPOLAR_EN
  localparam int POS_MAX_I = (1 << (WIDTH-1)) - 1;
  localparam int NEG_MIN_I = -(1 << (WIDTH-1));
  localparam int LEN_I     = sc_window_len(WIDTH);
  localparam logic signed [WIDTH:0] POS_MAX = POS_MAX_I[WIDTH:0];
  localparam logic signed [WIDTH:0] NEG_MIN = NEG_MIN_I[WIDTH:0];
  localparam logic signed [WIDTH:0] LEN     = LEN_I[WIDTH:0];

  logic signed [WIDTH:0] bipolar;

  // 2*ones-L always lies within +/-L, so WIDTH+1 bit wrap-around arithmetic is exact.
  assign bipolar = $signed({ones_final, 1'b0}) - LEN;

  always_comb begin
    result = bipolar[WIDTH-1:0];
    if (bipolar > POS_MAX) begin
      result = POS_MAX[WIDTH-1:0];
    end else if (bipolar < NEG_MIN) begin
      result = NEG_MIN[WIDTH-1:0];
    end
  end
`else
  assign result = ones_final;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_COUNT;
        end
        ST_COUNT: begin
          if (samp_tc) begin
            state_nxt = ST_DONE;
            load_res  = 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // out_value deliberately survives clear; only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_value <= '0;
    end else if (load_res) begin
      out_value <= result;
    end
  end

  assign busy      = (state == ST_COUNT);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomized scoreboard bench for sc_stream_decoder (WIDTH=8), unipolar or bipolar build.
module tb_sc_stream_decoder;

  localparam int W = 8;
  localparam int L = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         clear;
  logic         in_valid;
  logic         in_bit;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];

  sc_stream_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the count of ones.
  function automatic logic [W-1:0] model(input int ones);
    int v;
`ifdef SC_DECODER_BIPOLAR_EN
    v = 2 * ones - L;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`else
    v = ones;
`endif
    return v[W-1:0];
  endfunction

  function automatic logic pat(input int mode, input int n);
    case (mode)
      0:       return (n % 2 == 0);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation on every handshake and checks hold stability.
  initial begin
    logic         prev_vld;
    logic         prev_hs;
    logic [W-1:0] prev_val;
    prev_vld = 1'b0;
    prev_hs  = 1'b0;
    prev_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
        prev_hs  = 1'b0;
      end else begin
        if (out_valid && prev_vld && !prev_hs) check("hold_stable", out_value, prev_val);
        if (out_valid && out_ready && !clear) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got 0x%0h expected none", out_value);
          end else begin
            check("result", out_value, exp_q.pop_front());
          end
          prev_hs = 1'b1;
        end else begin
          prev_hs = 1'b0;
        end
        prev_vld = out_valid;
        prev_val = out_value;
      end
    end
  end

  task automatic feed_valid(input int count);
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom % 2);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_window(input int mode, input bit gaps, input int ready_wait, input bit end_clear);
    int   ones;
    int   n;
    bit   gap_done;
    logic b;
    ones     = 0;
    n        = 0;
    gap_done = 1'b0;
    // The sample presented alongside start must not be counted.
    start    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on_start", busy, 1);
    while (n < L) begin
      if (gaps && !gap_done && n == 100) begin
        in_valid = 1'b0;
        in_bit   = 1'b1;
        for (int g = 0; g < 20; g++) begin
          tick();
          check("busy_in_gap", busy, 1);
        end
        gap_done = 1'b1;
      end
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom % 2);
      end else begin
        b        = pat(mode, n);
        in_valid = 1'b1;
        in_bit   = b;
        ones     += int'(b);
        n++;
      end
      if (n == L && !end_clear) exp_q.push_back(model(ones));
      tick();
      if (n < L) check("busy_in_count", busy, 1);
    end
    in_valid = 1'b0;
    check("out_valid_latency", out_valid, 1);
    check("busy_in_done", busy, 0);
    if (end_clear) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_done_valid", out_valid, 0);
      check("clear_done_busy", busy, 0);
      check("clear_keeps_value", out_value, model(ones));
    end else begin
      out_ready = 1'b0;
      for (int i = 0; i < ready_wait; i++) begin
        start = (i == 3);
        tick();
      end
      start = 1'b0;
      check("start_ignored_in_done", busy, 0);
      check("valid_held", out_valid, 1);
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      check("valid_after_hs", out_valid, 0);
      check("start_ignored_at_hs", busy, 0);
    end
    tick();
    check("idle_after_window", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_value", out_value, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    run_window(0, 1'b0, 0, 1'b0);
    run_window(1, 1'b0, 2, 1'b0);
    run_window(2, 1'b0, 1, 1'b0);
    run_window(0, 1'b1, 0, 1'b0);
    run_window(0, 1'b0, 10, 1'b0);

    // Abort at sample 50; no result may appear afterwards.
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_valid(50);
    out_ready = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count_busy", busy, 0);
    check("clear_count_valid", out_valid, 0);
    feed_valid(300);
    check("no_result_after_clear", out_valid, 0);
    out_ready = 1'b0;

    run_window(1, 1'b0, 0, 1'b1);
    run_window(3, 1'b1, 0, 1'b0);

    // Asynchronous reset in the middle of a window.
    start = 1'b1;
    tick();
    start = 1'b0;
    feed_valid(100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_value", out_value, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_window(3, 1'b0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      run_window(3, 1'($urandom % 2), $urandom_range(4), 1'b0);
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
